// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared constants and slot state type for the 1-to-4 stream demux.
// Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1to4_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_stream_if
// Brief    : Input stream and four output channels of the 1-to-4 demux.
//            Counter signals exist only when DEMUX_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
interface demux_1to4_stream_if #(
    parameter int WIDTH = 4
);
    import demux_pkg::*;

    logic [WIDTH-1:0]  in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  c;
    logic [WIDTH-1:0]  d;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_c;
    logic [CNT_W-1:0]  cnt_d;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, a, b, c, d, out_valid, cnt_a, cnt_b, cnt_c, cnt_d
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, a, b, c, d, out_valid, cnt_a, cnt_b, cnt_c, cnt_d
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, a, b, c, d, out_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, a, b, c, d, out_valid
    );
`endif

endinterface : demux_1to4_stream_if
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Brief    : One-entry valid/ready register slot for a single demux channel,
//            with an accepted-beat counter when DEMUX_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] in_data,
    input  wire logic             out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]      cnt
`endif
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // A load while FULL implies the consumer drained this cycle, so we stay FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (load)               w_state_nxt = FULL;
            FULL:    if (out_ready && !load) w_state_nxt = EMPTY;
            default:                         w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_data <= '0;
        else if (load) r_data <= in_data;
    end

    assign data = r_data;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_cnt <= '0;
        else if (load) r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;
`endif

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_stream
// Brief    : Registered 1-to-4 stream demux; select decode and in_ready only,
//            per-channel storage lives in demux_slot. Option: DEMUX_CNT_EN.
// Revision : 1.0
// ============================================================================
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    demux_1to4_stream_if.slave  bus
);

    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_load;
    logic [WIDTH-1:0]  w_data [NUM_CH];
    logic              w_in_ready;
    logic              w_accept;

    // Only the selected slot gates acceptance; other channels never stall input.
    assign w_in_ready = !w_valid[bus.in_sel] || bus.out_ready[bus.in_sel];
    assign w_accept   = bus.in_valid && w_in_ready;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] w_cnt [NUM_CH];
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign w_load[k] = w_accept && (bus.in_sel == SEL_W'(k));

        demux_slot #(
            .WIDTH     (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load[k]),
            .in_data   (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_valid (w_valid[k]),
            .data      (w_data[k])
`ifdef DEMUX_CNT_EN
            ,
            .cnt       (w_cnt[k])
`endif
        );
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.a         = w_data[0];
    assign bus.b         = w_data[1];
    assign bus.c         = w_data[2];
    assign bus.d         = w_data[3];

`ifdef DEMUX_CNT_EN
    assign bus.cnt_a = w_cnt[0];
    assign bus.cnt_b = w_cnt[1];
    assign bus.cnt_c = w_cnt[2];
    assign bus.cnt_d = w_cnt[3];
`endif

endmodule : demux_1to4_stream
`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to4_stream
// Brief    : Self-checking bench: vector table plus per-channel scoreboard.
// Revision : 1.0
// ============================================================================
module tb_demux_1to4_stream;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    demux_1to4_stream_if #(.WIDTH(4)) bus ();

    demux_1to4_stream #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [3:0] din;
        logic [3:0] ord;
        logic       rdy;
        logic [3:0] ov;
    } vec_t;

    vec_t       vecs [18];
    logic [3:0] q [4][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [3:0] chdata(input int k);
        case (k)
            0:       return bus.a;
            1:       return bus.b;
            2:       return bus.c;
            default: return bus.d;
        endcase
    endfunction

    // Drive one cycle starting just after a rising edge; expected words ride the queues.
    task automatic apply(input logic iv, input logic [1:0] s, input logic [3:0] din,
                         input logic [3:0] ord, input logic exp_rdy,
                         input logic [3:0] exp_ov, input string nm);
        logic [3:0] w;
        bus.in_valid  = iv;
        bus.in_sel    = s;
        bus.in_data   = din;
        bus.out_ready = ord;
        #1;
        chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            if (bus.out_valid[k] && ord[k]) begin
                if (q[k].size() == 0) begin
                    n_total++;
                    $display("FAIL %s.xfer_ch%0d: got unexpected word 0x%0h expected none",
                             nm, k, chdata(k));
                end else begin
                    w = q[k].pop_front();
                    chk($sformatf("%s.xfer_ch%0d", nm, k), 32'(chdata(k)), 32'(w));
                end
            end
        end
        if (iv && bus.in_ready) q[s].push_back(din);
        @(posedge clk);
        #1;
        chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
        for (int k = 0; k < 4; k++) begin
            if (bus.out_valid[k] && q[k].size() > 0)
                chk($sformatf("%s.data_ch%0d", nm, k), 32'(chdata(k)), 32'(q[k][0]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        // iv, sel, din, out_ready, expected in_ready, expected out_valid after edge
        vecs[0]  = '{1'b1, 2'd0, 4'h3, 4'b1111, 1'b1, 4'b0001};
        vecs[1]  = '{1'b1, 2'd1, 4'h5, 4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{1'b1, 2'd2, 4'hA, 4'b1111, 1'b1, 4'b0100};
        vecs[3]  = '{1'b1, 2'd3, 4'hF, 4'b1111, 1'b1, 4'b1000};
        vecs[4]  = '{1'b0, 2'd3, 4'hF, 4'b1111, 1'b1, 4'b0000};
        vecs[5]  = '{1'b1, 2'd2, 4'h7, 4'b1011, 1'b1, 4'b0100};
        vecs[6]  = '{1'b1, 2'd2, 4'h9, 4'b1011, 1'b0, 4'b0100};
        vecs[7]  = '{1'b1, 2'd2, 4'h9, 4'b1011, 1'b0, 4'b0100};
        vecs[8]  = '{1'b1, 2'd2, 4'h9, 4'b1111, 1'b1, 4'b0100};
        vecs[9]  = '{1'b0, 2'd3, 4'hF, 4'b1111, 1'b1, 4'b0000};
        vecs[10] = '{1'b1, 2'd1, 4'h4, 4'b1101, 1'b1, 4'b0010};
        vecs[11] = '{1'b1, 2'd0, 4'h1, 4'b1101, 1'b1, 4'b0011};
        vecs[12] = '{1'b1, 2'd0, 4'h2, 4'b1101, 1'b1, 4'b0011};
        vecs[13] = '{1'b0, 2'd3, 4'hF, 4'b1101, 1'b1, 4'b0010};
        vecs[14] = '{1'b0, 2'd3, 4'hF, 4'b1111, 1'b1, 4'b0000};
        vecs[15] = '{1'b1, 2'd3, 4'h6, 4'b0111, 1'b1, 4'b1000};
        vecs[16] = '{1'b1, 2'd3, 4'hE, 4'b1111, 1'b1, 4'b1000};
        vecs[17] = '{1'b0, 2'd3, 4'hF, 4'b1111, 1'b1, 4'b0000};

        // Reset with a live request: in_ready is combinational but nothing is taken.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 4'h8;
        bus.out_ready = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.data", {16'd0, bus.a, bus.b, bus.c, bus.d}, 32'd0);
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        for (int i = 0; i < 18; i++)
            apply(vecs[i].iv, vecs[i].sel, vecs[i].din, vecs[i].ord,
                  vecs[i].rdy, vecs[i].ov, $sformatf("vec%0d", i));

        // Mid-stream reset with a and c holding words.
        apply(1'b1, 2'd0, 4'h8, 4'b0000, 1'b1, 4'b0001, "mid_load_a");
        apply(1'b1, 2'd2, 4'hC, 4'b0000, 1'b1, 4'b0101, "mid_load_c");
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        chk("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst.data", {16'd0, bus.a, bus.b, bus.c, bus.d}, 32'd0);
        for (int k = 0; k < 4; k++) q[k].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef DEMUX_CNT_EN
        for (int i = 0; i < 257; i++)
            apply(1'b1, 2'd1, 4'(i), 4'b1111, 1'b1, 4'b0010, "cnt_fill");
        apply(1'b0, 2'd3, 4'h0, 4'b1111, 1'b1, 4'b0000, "cnt_drain");
        chk("cnt_b_wrap", 32'(bus.cnt_b), 32'd1);
        chk("cnt_acd_zero", {8'd0, bus.cnt_a, bus.cnt_c, bus.cnt_d}, 32'd0);
`endif

        apply(1'b1, 2'd1, 4'h5, 4'b1111, 1'b1, 4'b0010, "post_rst_b");
        apply(1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, "post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_demux_1to4_stream
`default_nettype wire
